// File: rtl/noc_pkg.sv
// Shared definitions for the NoC datapath: flit width and flit type.
package noc_pkg;
  localparam int FLIT_W = 16;
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/sync_buf.sv
// Single-clock circular buffer with push/pop and an occupancy count.
// Head is combinational from the read pointer and reads as zero when empty.
module sync_buf #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (occ != '0);
  assign head   = (occ != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // The upstream issue rule reserves a slot for every in-flight word.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && occ == OW'(DEPTH)));

endmodule

// File: rtl/fifo_rd_adapter.sv
// FIFO read-side adapter: issues reads ahead of the fixed RAM latency and
// lands returned words in a local buffer presented as a valid/ready stream.
module fifo_rd_adapter
  import noc_pkg::*;
#(
  parameter int DW     = FLIT_W,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_read,
  input  logic [DW-1:0]              fifo_dout,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int IW = $clog2(RD_LAT+1);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("fifo_rd_adapter: RD_LAT must be 1..4");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_rd_adapter: DEPTH must be at least 2");
  end

  logic [RD_LAT-1:0] inflight_sh;
  logic [IW-1:0]     inflight;
  logic              tap;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(inflight_sh[i]);
  end

  assign tap = inflight_sh[RD_LAT-1];

  // Current-cycle pop is left out on purpose: no out_ready -> fifo_read path.
  assign fifo_read = ~rst & ~fifo_empty & ((int'(occ) + int'(inflight)) < DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_sh <= '0;
    end else begin
      inflight_sh[0] <= fifo_read & ~fifo_empty;
      for (int i = 1; i < RD_LAT; i++) inflight_sh[i] <= inflight_sh[i-1];
    end
  end

  sync_buf #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (tap),
    .push_data (fifo_dout),
    .pop       (out_ready),
    .head      (out_data),
    .occ       (occ)
  );

  assign out_valid = (occ != '0);

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: a behavioural FIFO read side (RD_LAT=1) feeds
// the DUT; words loaded into it are queued as expected stream output.
module tb_fifo_rd_adapter;
  import noc_pkg::*;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_read;
  flit_t       fifo_dout;
  logic        out_valid;
  flit_t       out_data;
  logic        out_ready;
  logic [2:0]  occ;

  flit_t fq[$];
  flit_t exp_q[$];
  int    total;
  int    bad;
  int    n_out;
  int    n_out0;
  int    vcount;
  logic  model_acc;

  fifo_rd_adapter #(.DW(16), .RD_LAT(1), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occ        (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input flit_t w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && fq.size() == 0 && !out_valid) && n < bound) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= bound) begin
      bad++;
      $display("FAIL %s: drain not finished after %0d cycles, %0d words left", name, n, exp_q.size());
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    n_out      = 0;
    rst        = 1'b1;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    model_acc  = 1'b0;

    fork
      // FIFO read side: data appears one cycle after an accepted read.
      forever begin
        @(negedge clk);
        model_acc = fifo_read & ~fifo_empty;
        @(posedge clk);
        #2;
        if (model_acc && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
      end
      // Output monitor: every handshake must match the next expected word.
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          total++;
          n_out++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL out_order: got %h expected no word", out_data);
          end else begin
            flit_t e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
              bad++;
              $display("FAIL out_order: got %h expected %h", out_data, e);
            end
          end
        end
      end
    join_none

    @(negedge clk);
    chk("rst_fifo_read", fifo_read, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_occ", occ, 3'd0);
    step();
    rst = 1'b0;
    step();
    step();

    // Single word with cycle-accurate latency.
    push_word(16'hA5A5);
    @(negedge clk);
    chk("single_c0_read", fifo_read, 1'b1);
    chk("single_c0_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("single_c1_read", fifo_read, 1'b0);
    chk("single_c1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("single_c2_valid", out_valid, 1'b1);
    chk("single_c2_data", out_data, 16'hA5A5);
    @(negedge clk);
    chk("single_c3_occ", occ, 3'd0);
    chk("single_c3_valid", out_valid, 1'b0);

    // Streaming: 16 words, one per cycle with no gaps.
    step();
    for (int i = 0; i < 16; i++) push_word(flit_t'(i));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("stream_start", out_valid, 1'b1);
    vcount = 0;
    for (int k = 0; k < 16; k++) begin
      if (out_valid) vcount++;
      @(negedge clk);
    end
    chk("stream_run", vcount, 16);
    chk("stream_end", out_valid, 1'b0);
    wait_drain("stream_drain", 20);

    // Backpressure: buffer saturates, reads stop, head holds.
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'h0100 + flit_t'(i));
    repeat (10) @(negedge clk);
    chk("bp_occ", occ, 3'd4);
    chk("bp_read", fifo_read, 1'b0);
    chk("bp_valid", out_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_data_stable", out_data, 16'h0100);
      chk("bp_read_low", fifo_read, 1'b0);
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    wait_drain("bp_drain", 30);

    // FIFO goes empty after three reads; last one is still in flight.
    step();
    n_out0 = n_out;
    for (int i = 0; i < 3; i++) push_word(16'h0300 + flit_t'(i));
    wait_drain("empty_drain", 20);
    chk("empty_count", n_out - n_out0, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("empty_valid", out_valid, 1'b0);
      chk("empty_read", fifo_read, 1'b0);
    end

    // Push and pop in the same cycle at occ=3.
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(16'h0400 + flit_t'(i));
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pp_occ_before", occ, 3'd3);
    @(negedge clk);
    chk("pp_occ_after", occ, 3'd3);
    wait_drain("pp_drain", 30);

    // Reset with two buffered words and one in flight.
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(16'h0500 + flit_t'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_pre_occ", occ, 3'd2);
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_occ", occ, 3'd0);
    chk("rst_mid_read", fifo_read, 1'b0);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    n_out0 = n_out;
    push_word(16'h0600);
    push_word(16'h0601);
    wait_drain("rst_refill_drain", 20);
    chk("rst_refill_count", n_out - n_out0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
